// File: rtl/seq_word_comparator_pkg.sv
// Shared definitions for the sequential word comparator.
// State encoding and cascade flag bundle.
package seq_word_comparator_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } flags_t;

  // Cascade seed: an empty prefix compares equal
  localparam flags_t FLAGS_INIT = 3'b010;
  localparam flags_t FLAGS_CLR  = 3'b000;

endpackage

// File: rtl/seq_word_comparator_slice.sv
// Cascadable N-bit unsigned magnitude comparator slice.
// A differing slice overrides the cascade; equal slices pass it on.
module n_bit_comparator #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         gt_in,
  input  logic         eq_in,
  input  logic         lt_in,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  always_comb begin
    gt = gt_in;
    eq = eq_in;
    lt = lt_in;
    unique case (1'b1)
      (a > b): begin
        gt = 1'b1;
        eq = 1'b0;
        lt = 1'b0;
      end
      (a < b): begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_word_comparator.sv
// Multi-cycle wide comparator reusing one slice, LSB slice first.
// Slice flags are registered and fed back as the next cascade input.
module seq_word_comparator
  import seq_word_comparator_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 2,
  parameter int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic               a_gt_b,
  output logic               a_eq_b,
  output logic               a_lt_b
);

  localparam int W = N * WORDS;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  flags_t        w_q, w_d;
  flags_t        res_q, res_d;

  logic [N-1:0]  sl_a;
  logic [N-1:0]  sl_b;
  flags_t        sl;

  assign sl_a = a_q[int'(idx_q) * N +: N];
  assign sl_b = b_q[int'(idx_q) * N +: N];

  n_bit_comparator #(
    .N (N)
  ) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .gt_in (w_q.gt),
    .eq_in (w_q.eq),
    .lt_in (w_q.lt),
    .gt    (sl.gt),
    .eq    (sl.eq),
    .lt    (sl.lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    res_d   = res_q;
    case (state_q)
      S_RUN: begin
        w_d = sl;
        if (idx_q == LAST) begin
          res_d   = sl;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          w_d     = FLAGS_INIT;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= FLAGS_INIT;
      res_q   <= FLAGS_CLR;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign a_gt_b = res_q.gt;
  assign a_eq_b = res_q.eq;
  assign a_lt_b = res_q.lt;

endmodule
